// File: rtl/controlador_balanca_if.sv
// Panel/load-cell and accumulator signal bundle for controlador_balanca.
// slave: the sequencer itself; master: whatever drives the panel inputs and observes the accumulator side.
interface controlador_balanca_if;
    logic [10:0] peso_sensor;
    logic [10:0] preco_kg;
    logic        item_req;
    logic        cancelar;
    logic        botao_fim;
    logic        botao_taxa;
    logic        talao_pronto;
    logic [10:0] preco_produto;
    logic [10:0] peso_produto;
    logic        fim_compra;
    logic        taxa;
    logic        acum_clr;
    logic        pedido_talao;
    logic        item_ack;
    logic        item_rej;
    logic        saturou;
    logic [4:0]  n_itens;
    logic        busy;

    modport slave (
        input  peso_sensor, preco_kg, item_req, cancelar, botao_fim, botao_taxa, talao_pronto,
        output preco_produto, peso_produto, fim_compra, taxa, acum_clr, pedido_talao,
               item_ack, item_rej, saturou, n_itens, busy
    );

    modport master (
        output peso_sensor, preco_kg, item_req, cancelar, botao_fim, botao_taxa, talao_pronto,
        input  preco_produto, peso_produto, fim_compra, taxa, acum_clr, pedido_talao,
               item_ack, item_rej, saturou, n_itens, busy
    );
endinterface

// File: rtl/controlador_balanca.sv
// Checkout sequencer feeding the price/weight accumulator: weigh, price, add, close, print, clear.
// Optional OVERFLOW_GUARD_EN keeps a shadow price sum and refuses items that would pass 2047.
module controlador_balanca #(
    parameter int ESTAVEL_CICLOS = 4,
    parameter int SHIFT          = 10,
    parameter int MAX_ITENS      = 31
) (
    input  logic clk,
    input  logic rst,
    controlador_balanca_if.slave bus
);
    localparam int CW = (ESTAVEL_CICLOS > 2) ? $clog2(ESTAVEL_CICLOS) : 1;

    typedef enum logic [2:0] {IDLE, ESTAB, CALC, SOMA, FECHO, TALAO, LIMPA} state_t;

    state_t      state_q, state_d;
    logic [10:0] preco_lat_q, preco_lat_d;
    logic [10:0] peso_lat_q, peso_lat_d;
    logic [10:0] peso_prev_q, peso_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0] preco_produto_q, preco_produto_d;
    logic [10:0] peso_produto_q, peso_produto_d;
    logic        fim_compra_q, fim_compra_d;
    logic        taxa_q, taxa_d;
    logic        acum_clr_q, acum_clr_d;
    logic        pedido_talao_q, pedido_talao_d;
    logic        item_ack_q, item_ack_d;
    logic        item_rej_q, item_rej_d;
    logic        saturou_q, saturou_d;
    logic [4:0]  n_itens_q, n_itens_d;
    logic        busy_q, busy_d;

    logic [21:0] prod_w;
    logic [21:0] preco_sh;
    logic        sat_w;
    logic [10:0] preco_calc;
    logic        recusa_w;

    assign prod_w     = 22'(peso_lat_q) * 22'(preco_lat_q);
    assign preco_sh   = prod_w >> SHIFT;
    assign sat_w      = |preco_sh[21:11];
    assign preco_calc = sat_w ? 11'h7FF : preco_sh[10:0];

`ifdef OVERFLOW_GUARD_EN
    logic [11:0] shadow_q, shadow_d;
    logic [11:0] soma_w;
    assign soma_w   = shadow_q + {1'b0, preco_calc};
    assign recusa_w = (soma_w > 12'd2047);
`else
    assign recusa_w = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        preco_lat_d     = preco_lat_q;
        peso_lat_d      = peso_lat_q;
        peso_prev_d     = bus.peso_sensor;
        cnt_d           = cnt_q;
        preco_produto_d = '0;
        peso_produto_d  = '0;
        fim_compra_d    = 1'b0;
        taxa_d          = 1'b0;
        acum_clr_d      = 1'b0;
        item_ack_d      = 1'b0;
        item_rej_d      = 1'b0;
        saturou_d       = saturou_q;
        n_itens_d       = n_itens_q;
`ifdef OVERFLOW_GUARD_EN
        shadow_d        = shadow_q;
`endif
        case (state_q)
            IDLE: begin
                // item_req outranks botao_fim; a held botao_fim is picked up on a later IDLE cycle
                if (bus.item_req) begin
                    if (n_itens_q < 5'(MAX_ITENS)) begin
                        preco_lat_d = bus.preco_kg;
                        cnt_d       = '0;
                        state_d     = ESTAB;
                    end else begin
                        item_rej_d  = 1'b1;
                    end
                end else if (bus.botao_fim && (n_itens_q != 5'd0)) begin
                    fim_compra_d = 1'b1;
                    taxa_d       = bus.botao_taxa;
                    state_d      = FECHO;
                end
            end
            ESTAB: begin
                if (bus.cancelar) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(ESTAVEL_CICLOS - 1)) begin
                    peso_lat_d = peso_prev_q;
                    state_d    = CALC;
                end else if ((bus.peso_sensor != 11'd0) && (bus.peso_sensor == peso_prev_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            CALC: begin
                if (recusa_w) begin
                    item_rej_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    preco_produto_d = preco_calc;
                    peso_produto_d  = peso_lat_q;
                    item_ack_d      = 1'b1;
                    saturou_d       = saturou_q | sat_w;
`ifdef OVERFLOW_GUARD_EN
                    shadow_d        = soma_w;
`endif
                    state_d         = SOMA;
                end
            end
            SOMA: begin
                n_itens_d = n_itens_q + 5'd1;
                state_d   = IDLE;
            end
            FECHO: begin
                state_d = TALAO;
            end
            TALAO: begin
                if (bus.talao_pronto) begin
                    acum_clr_d = 1'b1;
                    n_itens_d  = 5'd0;
                    saturou_d  = 1'b0;
`ifdef OVERFLOW_GUARD_EN
                    shadow_d   = '0;
`endif
                    state_d    = LIMPA;
                end
            end
            LIMPA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pedido_talao_d = (state_d == TALAO);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            preco_lat_q     <= '0;
            peso_lat_q      <= '0;
            peso_prev_q     <= '0;
            cnt_q           <= '0;
            preco_produto_q <= '0;
            peso_produto_q  <= '0;
            fim_compra_q    <= 1'b0;
            taxa_q          <= 1'b0;
            acum_clr_q      <= 1'b0;
            pedido_talao_q  <= 1'b0;
            item_ack_q      <= 1'b0;
            item_rej_q      <= 1'b0;
            saturou_q       <= 1'b0;
            n_itens_q       <= '0;
            busy_q          <= 1'b0;
`ifdef OVERFLOW_GUARD_EN
            shadow_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            preco_lat_q     <= preco_lat_d;
            peso_lat_q      <= peso_lat_d;
            peso_prev_q     <= peso_prev_d;
            cnt_q           <= cnt_d;
            preco_produto_q <= preco_produto_d;
            peso_produto_q  <= peso_produto_d;
            fim_compra_q    <= fim_compra_d;
            taxa_q          <= taxa_d;
            acum_clr_q      <= acum_clr_d;
            pedido_talao_q  <= pedido_talao_d;
            item_ack_q      <= item_ack_d;
            item_rej_q      <= item_rej_d;
            saturou_q       <= saturou_d;
            n_itens_q       <= n_itens_d;
            busy_q          <= busy_d;
`ifdef OVERFLOW_GUARD_EN
            shadow_q        <= shadow_d;
`endif
        end
    end

    assign bus.preco_produto = preco_produto_q;
    assign bus.peso_produto  = peso_produto_q;
    assign bus.fim_compra    = fim_compra_q;
    assign bus.taxa          = taxa_q;
    assign bus.acum_clr      = acum_clr_q;
    assign bus.pedido_talao  = pedido_talao_q;
    assign bus.item_ack      = item_ack_q;
    assign bus.item_rej      = item_rej_q;
    assign bus.saturou       = saturou_q;
    assign bus.n_itens       = n_itens_q;
    assign bus.busy          = busy_q;
endmodule
